pwm_peripheral: RTL



---
 rtl/pwm_peripheral.sv | 60 ++++++
 1 files changed

// File: rtl/pwm_peripheral.sv
// 16-pin output stage driven by enable registers and a shared, period-buffered 8-bit PWM.
// Each pin is forced low, held static high, or follows the PWM waveform.
module pwm_peripheral #(
   parameter int unsigned CLK_DIV = 13
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  en_reg_out_7_0,
   input  logic [7:0]  en_reg_out_15_8,
   input  logic [7:0]  en_reg_pwm_7_0,
   input  logic [7:0]  en_reg_pwm_15_8,
   input  logic [7:0]  pwm_duty_cycle,
   output logic [15:0] out,
   output logic        period_start
);

   localparam logic [11:0] DivLast = 12'(CLK_DIV - 1);

   logic [11:0] prescaler_q, prescaler_d;
   logic [7:0]  counter_q, counter_d;
   logic [7:0]  duty_q, duty_d;
   logic [15:0] out_d;
   logic        period_start_d;
   logic [15:0] en_out, en_pwm;
   logic        tick, boundary, pwm_raw;

   assign en_out = {en_reg_out_15_8, en_reg_out_7_0};
   assign en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};

   assign tick     = (prescaler_q == DivLast);
   assign boundary = tick && (counter_q == 8'hFF);

   // 0xFF is special-cased to a solid high; otherwise the last count would always be low.
   assign pwm_raw = (duty_q == 8'hFF) || (counter_q < duty_q);

   always_comb begin
      prescaler_d    = tick ? 12'd0 : prescaler_q + 12'd1;
      counter_d      = tick ? counter_q + 8'd1 : counter_q;
      duty_d         = boundary ? pwm_duty_cycle : duty_q;
      period_start_d = boundary;
      out_d          = en_out & (~en_pwm | {16{pwm_raw}});
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prescaler_q  <= 12'd0;
         counter_q    <= 8'd0;
         duty_q       <= 8'd0;
         out          <= 16'h0000;
         period_start <= 1'b0;
      end else begin
         prescaler_q  <= prescaler_d;
         counter_q    <= counter_d;
         duty_q       <= duty_d;
         out          <= out_d;
         period_start <= period_start_d;
      end
   end

endmodule
